// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide sequencer with a valid/ready request and response.
// Ports: clk, rst; req_valid/req_ready, func3, a, b, tag_in; kill; resp_valid/resp_ready, result, tag_out, busy.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier. By default the multiply uses the iterative engine.
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       func3,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             kill,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, MUL, DIV, SIGN, DONE} state_t;

    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    logic [2:0]        op;
    logic              neg;
    logic [4:0]        cnt;
    logic [XLEN-1:0]   opa;
    logic [XLEN-1:0]   opb;
    logic [XLEN:0]     rem;
    logic [2*XLEN-1:0] acc;

    assign req_ready = (state == IDLE) & ~kill;
    assign busy      = (state != IDLE);

    logic            sgn_a, sgn_b, sa, sb;
    logic            neg_in, div0, ovf;
    logic [XLEN-1:0] ma, mb, early;

    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        case (func3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                sgn_a = 1'b1;
                sgn_b = 1'b1;
            end
            3'b010:  sgn_a = 1'b1;
            default: ;
        endcase
        sa     = sgn_a & a[XLEN-1];
        sb     = sgn_b & b[XLEN-1];
        ma     = sa ? -a : a;
        mb     = sb ? -b : b;
        // The remainder takes the dividend's sign; everything else takes the xor.
        neg_in = (func3 == 3'b110) ? sa : (sa ^ sb);
        div0   = func3[2] & (b == '0);
        ovf    = func3[2] & ~func3[0] & (a == MINV) & (b == '1);
        if (div0)
            early = func3[1] ? a : '1;
        else
            early = func3[1] ? '0 : MINV;
    end

`ifdef MULDIV_FAST_MUL_EN
    // This is a 33x33 signed product. sa/sb act as the sign-extension bits.
    logic [2*XLEN-1:0] xa, xb, fp;
    logic [XLEN-1:0]   fres;

    always_comb begin
        xa   = {{XLEN{sa}}, a};
        xb   = {{XLEN{sb}}, b};
        fp   = xa * xb;
        fres = (func3[1:0] == 2'b00) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
    end
`endif

    // Each step computes one restoring-division bit and one shift-add multiply bit.
    logic [XLEN+1:0] r_sh, diff;
    logic            ge;
    logic [XLEN:0]   sum;

    always_comb begin
        r_sh = {rem, opa[XLEN-1]};
        diff = r_sh - {2'b00, opb};
        ge   = ~diff[XLEN+1];
        sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    end

    logic [2*XLEN-1:0] pr;
    logic [XLEN-1:0]   qv, rv, fin;

    always_comb begin
        pr = neg ? -acc : acc;
        qv = neg ? -opa : opa;
        rv = neg ? -rem[XLEN-1:0] : rem[XLEN-1:0];
        if (op[2])
            fin = op[1] ? rv : qv;
        else if (op[1:0] == 2'b00)
            fin = pr[XLEN-1:0];
        else
            fin = pr[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            result     <= '0;
            tag_out    <= '0;
        end else if (kill && state != IDLE) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (req_valid && !kill) begin
                    op      <= func3;
                    tag_out <= tag_in;
                    neg     <= neg_in;
                    opa     <= ma;
                    opb     <= mb;
                    rem     <= '0;
                    acc     <= {{XLEN{1'b0}}, ma};
                    cnt     <= 5'd31;
                    if (func3[2]) begin
                        if (div0 || ovf) begin
                            result     <= early;
                            resp_valid <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= DIV;
                        end
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        result     <= fres;
                        resp_valid <= 1'b1;
                        state      <= DONE;
`else
                        state <= MUL;
`endif
                    end
                end
                MUL: begin
                    acc <= {sum, acc[XLEN-1:1]};
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0)
                        state <= SIGN;
                end
                DIV: begin
                    opa <= {opa[XLEN-2:0], ge};
                    rem <= ge ? diff[XLEN:0] : r_sh[XLEN:0];
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0)
                        state <= SIGN;
                end
                SIGN: begin
                    result     <= fin;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vector table and multi-cycle corner sequences for muldiv_seq.
// It covers latency, result and tag checks, plus backpressure, kill and reset.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  func3 = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  tag_in = '0;
    logic        kill = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] result;
    logic [4:0]  tag_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int ML = 1;
`else
    localparam int ML = 34;
`endif

    muldiv_seq dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .func3      (func3),
        .a          (a),
        .b          (b),
        .tag_in     (tag_in),
        .kill       (kill),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .tag_out    (tag_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t v[16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (resp_valid && req_ready) begin
                errors++;
                $display("FAIL overlap: resp_valid and req_ready both 1 at %0t",
                         $time);
            end
        end
    end

    // This task is called at a negedge with the block idle. It returns at the first negedge after the accept edge.
    task automatic start_op(input logic [2:0] f, input logic [31:0] x,
                            input logic [31:0] y, input logic [4:0] t);
        func3     = f;
        a         = x;
        b         = y;
        tag_in    = t;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        func3     = ~f;
        a         = ~x;
        b         = ~y;
        tag_in    = ~t;
        @(negedge clk);
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_op;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        logic seen;

        v[0]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd1,  32'hFFFFFFFD, 34};
        v[1]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd2,  32'hFFFFFFFF, 34};
        v[2]  = '{3'b101, 32'd5,        32'd0,        5'd3,  32'hFFFFFFFF, 1};
        v[3]  = '{3'b111, 32'd5,        32'd0,        5'd4,  32'd5,        1};
        v[4]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd5,  32'h80000000, 1};
        v[5]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd6,  32'd0,        1};
        v[6]  = '{3'b001, 32'h80000000, 32'h80000000, 5'd7,  32'h40000000, ML};
        v[7]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, ML};
        v[8]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'hFFFFFFFE, ML};
        v[9]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 5'd10, 32'hFFFFFFEB, ML};
        v[10] = '{3'b000, 32'h12345678, 32'h10,       5'd11, 32'h23456780, ML};
        v[11] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'd0,        ML};
        v[12] = '{3'b100, 32'd7,        32'hFFFFFFFE, 5'd13, 32'hFFFFFFFD, 34};
        v[13] = '{3'b110, 32'd7,        32'hFFFFFFFE, 5'd14, 32'd1,        34};
        v[14] = '{3'b101, 32'hFFFFFFFF, 32'd1,        5'd15, 32'hFFFFFFFF, 34};
        v[15] = '{3'b100, 32'hFFFFFFF9, 32'd0,        5'd16, 32'hFFFFFFFF, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_tag", {27'd0, tag_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 16; i++) begin
            start_op(v[i].f, v[i].a, v[i].b, v[i].tag);
            wait_resp(lat);
            chk($sformatf("v%0d_lat", i), lat, v[i].lat);
            chk($sformatf("v%0d_res", i), result, v[i].exp);
            chk($sformatf("v%0d_tag", i), {27'd0, tag_out}, {27'd0, v[i].tag});
            finish_op();
            chk($sformatf("v%0d_idle", i), {31'd0, busy}, 32'd0);
        end

        start_op(3'b101, 32'd100, 32'd7, 5'd12);
        wait_resp(lat);
        chk("bp_lat", lat, 34);
        func3     = 3'b101;
        a         = 32'd50;
        b         = 32'd5;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_res%0d", i), result, 32'd14);
            chk($sformatf("bp_valid%0d", i), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("bp_ready%0d", i), {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        finish_op();
        chk("bp_idle_busy", {31'd0, busy}, 32'd0);
        chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_idle_valid", {31'd0, resp_valid}, 32'd0);
        chk("bp_tag", {27'd0, tag_out}, 32'd12);

        start_op(3'b100, 32'd1000, 32'd3, 5'd3);
        for (int n = 1; n < 10; n++)
            @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        @(negedge clk);
        chk("kill_idle", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen |= resp_valid;
            @(negedge clk);
        end
        chk("kill_no_resp", {31'd0, seen}, 32'd0);

        start_op(3'b100, 32'd9, 32'd3, 5'd21);
        wait_resp(lat);
        chk("post_kill_lat", lat, 34);
        chk("post_kill_res", result, 32'd3);
        finish_op();

        start_op(3'b100, 32'd1000, 32'd3, 5'd9);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_tag", {27'd0, tag_out}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
